// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg : shared types, segment bit order and hex glyph table.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seg7_pkg;

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  // Bit positions within the {g,f,e,d,c,b,a} segment vector
  localparam int c_seg_a = 0;
  localparam int c_seg_b = 1;
  localparam int c_seg_c = 2;
  localparam int c_seg_d = 3;
  localparam int c_seg_e = 4;
  localparam int c_seg_f = 5;
  localparam int c_seg_g = 6;

  localparam logic [6:0] c_glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return c_glyph[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver_if : value/dp load handshake for the scan driver.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    value_valid;
  logic                    value_ready;

  modport master (
    output value_in,
    output dp_in,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_in,
    input  dp_in,
    input  value_valid,
    output value_ready
  );
endinterface
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_decoder : nibble plus blank flag to active-high segments.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_decoder
  import seg7_pkg::*;
(
  input  wire logic [3:0] nibble,
  input  wire logic       blank,
  output logic      [6:0] seg
);

  always_comb begin
    seg = blank ? 7'h00 : hex_to_seg(nibble);
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver : double-buffered, blank-gapped multiplexed display.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  tick,
  input  wire logic                  lz_suppress,
  seg7_scan_driver_if.slave          bus,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [NUM_DIGITS-1:0]      an
);

  localparam int c_idx_w    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_cnt_w    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int c_cnt_load = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [6:0]            c_seg_off = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  c_dp_off  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] c_an_off  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);

  scan_state_t               r_state, w_state_nxt;
  logic [c_idx_w-1:0]        r_idx, w_idx_nxt;
  logic [c_cnt_w-1:0]        r_cnt, w_cnt_nxt;
  logic [4*NUM_DIGITS-1:0]   r_pend_val, w_pend_val_nxt, r_disp_val, w_disp_val_nxt;
  logic [NUM_DIGITS-1:0]     r_pend_dp, w_pend_dp_nxt, r_disp_dp, w_disp_dp_nxt;
  logic                      r_pend_full, w_pend_full_nxt;
  logic                      r_ready, w_ready_nxt;
  logic                      w_adv, w_wrap, w_accept;

  logic [3:0]                w_nibble;
  logic                      w_lz_blank, w_show;
  logic [6:0]                w_seg_dec, w_seg_hi;
  logic                      w_dp_hi;
  logic [NUM_DIGITS-1:0]     w_an_hi;

  assign w_accept        = bus.value_valid && r_ready;
  assign bus.value_ready = r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SHOW;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_disp_val  <= '0;
      r_disp_dp   <= '0;
      r_pend_full <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_val  <= w_pend_val_nxt;
      r_pend_dp   <= w_pend_dp_nxt;
      r_disp_val  <= w_disp_val_nxt;
      r_disp_dp   <= w_disp_dp_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_ready     <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_adv           = 1'b0;
    w_idx_nxt       = r_idx;
    w_wrap          = 1'b0;
    w_disp_val_nxt  = r_disp_val;
    w_disp_dp_nxt   = r_disp_dp;
    w_pend_val_nxt  = r_pend_val;
    w_pend_dp_nxt   = r_pend_dp;
    w_pend_full_nxt = r_pend_full;

    case (r_state)
      SHOW: begin
        if (tick) begin
          if (BLANK_CYCLES > 0) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = c_cnt_w'(c_cnt_load);
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      BLANK: begin
        // Ticks arriving here are dropped on purpose, never queued
        if (r_cnt == '0) begin
          w_adv       = 1'b1;
          w_state_nxt = SHOW;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = SHOW;
    endcase

    if (w_adv) begin
      w_wrap    = (r_idx == c_idx_last);
      w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
    end

    if (w_wrap && r_pend_full) begin
      w_disp_val_nxt  = r_pend_val;
      w_disp_dp_nxt   = r_pend_dp;
      w_pend_full_nxt = 1'b0;
    end else if (w_accept) begin
      w_pend_val_nxt  = bus.value_in;
      w_pend_dp_nxt   = bus.dp_in;
      w_pend_full_nxt = 1'b1;
    end

    // Ready stays low for one extra cycle after the frame-boundary transfer
    w_ready_nxt = !(r_pend_full || w_accept);
  end

  // Outputs are built from next-state values so they land with the state change
  always_comb begin
    w_show     = (w_state_nxt == SHOW);
    w_nibble   = w_disp_val_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_lz_blank = lz_suppress && (w_idx_nxt != '0) &&
                 ((w_disp_val_nxt >> {w_idx_nxt, 2'b00}) == '0);
    w_seg_hi   = w_show ? w_seg_dec : 7'h00;
    w_dp_hi    = w_show && w_disp_dp_nxt[w_idx_nxt];
    w_an_hi    = w_show ? (NUM_DIGITS'(1) << w_idx_nxt) : '0;
  end

  seg7_decoder u_decoder (
    .nibble (w_nibble),
    .blank  (w_lz_blank),
    .seg    (w_seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= c_seg_off;
      dp  <= c_dp_off;
      an  <= c_an_off;
    end else begin
      seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
      dp  <= (SEG_ACTIVE_LOW != 0) ? ~w_dp_hi  : w_dp_hi;
      an  <= (AN_ACTIVE_LOW  != 0) ? ~w_an_hi  : w_an_hi;
    end
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed 7-segment display driver, downstream of the enable-gated `counter`. Its `pulse` output is wired to `tick` here and paces digit scanning. It accepts a hex value through a valid/ready handshake, double-buffers it so digits change only at frame boundaries, and drives per-digit anodes with a blanking gap between digits to prevent ghosting. Optional leading-zero suppression is supported.

## Interface
- `NUM_DIGITS`, 4: digits scanned; digit 0 is least significant.
- `BLANK_CYCLES`, 2: clock cycles with all anodes off between digits; 0 is legal.
- `SEG_ACTIVE_LOW`, 1: inverts `seg` and `dp` at the output.
- `AN_ACTIVE_LOW`, 1: inverts `an` at the output.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  single-cycle scan-advance strobe, from `counter.pulse`.
- `value_in`  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k.
- `dp_in`  in  NUM_DIGITS  decimal-point bits, latched with `value_in`.
- `value_valid`  in  1  `value_in`/`dp_in` are presented.
- `value_ready`  out  1  pending buffer is empty; a transfer occurs when valid && ready.
- `lz_suppress`  in  1  blank leading zeros; sampled live.
- `seg`  out  7  {g,f,e,d,c,b,a}, registered.
- `dp`  out  1  decimal point, registered.
- `an`  out  NUM_DIGITS  one-hot digit enable, registered.

## Operation
- **Registers**
  - `pend` (value + dp) with flag `pend_full`.
  - `disp` (value + dp).
  - `idx` (0..NUM_DIGITS-1).
  - Blank counter.
  - State.
- **States:** SHOW, BLANK.
- **SHOW**
  - `an` has the active level on bit `idx` only.
  - On `tick`: if BLANK_CYCLES > 0, go to BLANK and load counter = BLANK_CYCLES-1. Otherwise advance directly (see below).
- **BLANK**
  - All anodes inactive; `seg`/`dp` inactive.
  - `tick` is ignored; it is not queued.
  - When counter = 0, advance and return to SHOW. Otherwise decrement.
- **Advance**
  - `idx` ← `idx`+1, wrapping NUM_DIGITS-1 → 0.
  - On wrap with `pend_full`: `disp` ← `pend` and `pend_full` ← 0 in the same cycle, so the new digit 0 shows the new value.
- **Handshake**
  - `value_ready` = !`pend_full`, registered.
  - Accept (valid && ready) sets `pend_full`; a second write waits for the frame boundary.
  - Accept in the same cycle as a wrap transfer cannot occur, since ready=0 whenever `pend_full`=1.
- **Decode**
  - Digits 0-F use the standard hex glyphs. Active-high codes: 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71.
  - Output polarity is applied after decode.
- **Leading-zero suppression**
  - When `lz_suppress`=1, digit k≠0 is blanked (`seg` inactive) if nibbles k..NUM_DIGITS-1 of `disp` are all zero.
  - Digit 0 is never suppressed.
  - `dp` is never suppressed.
  - Blanking only affects `seg`; `an` still asserts, which keeps brightness uniform.

## Timing
- **Reset values:** state=SHOW, `idx`=0, `disp`=0, `pend_full`=0, `value_ready`=1.
  - With SEG_ACTIVE_LOW=1, `seg`=7'h7F and `dp`=1, both inactive.
  - With AN_ACTIVE_LOW=1, `an` = all ones, inactive.
  - The first registered update after reset release shows digit 0 = "0".
- **Tick latency:** `tick` high at cycle t (SHOW).
  - Anodes are off during cycles t+1..t+BLANK_CYCLES.
  - The new `an`/`seg` are valid at t+1+BLANK_CYCLES.
  - With BLANK_CYCLES=0, the new digit appears at t+1.
- **Handshake latency:** `value_ready` drops the cycle after accept. It rises the cycle after the wrap transfer.
- `seg`, `dp`, `an` change only on clock edges. All three come from the same register stage, so there is no skew between them.
- **Reset mid-frame or mid-blank:** all registers return immediately (asynchronously) to their reset values. Pending data is discarded.

## Structure
- **Package `seg7_pkg`:**
  - State enum `scan_state_t` {SHOW, BLANK}.
  - Segment bit-order constants.
  - Glyph lookup constant array for 0-F.
  - Function `hex_to_seg(logic [3:0]) -> logic [6:0]` (active-high).
- **Sub-module `seg7_decoder`:** combinational nibble + blank flag → active-high segments; instantiated once on the `disp` nibble selected by `idx`.
- Polarity inversion and the output registers live in the top.

## Test plan
All scenarios use NUM_DIGITS=4, BLANK_CYCLES=2, active-low outputs, and a `counter` with max_count=50 driving `tick`.
1. **Reset:** assert `reset` mid-operation → `an`=4'hF, `seg`=7'h7F, `value_ready`=1 immediately. After release, digit 0 shows 7'h40 ("0").
2. **Scan order:** write 16'h1A8F and let it run 8 ticks.
   - `an` sequence 1110,1101,1011,0111 repeats.
   - `seg` shows F=7'h0E, 8=7'h00, A=7'h08, 1=7'h79.
   - Exactly 2 all-off cycles precede each change.
3. **Frame-boundary update:** write 16'h1234 mid-frame on digit 1.
   - Digits 2 and 3 still show the old value.
   - `value_ready`=0 until the wrap.
   - The wrap cycle shows digit 0 = "4"; `value_ready` returns to 1 the next cycle.
4. **Backpressure:** hold `value_valid` with 16'h5555 then 16'h6666 inside one frame → only 16'h5555 is accepted before the wrap; 16'h6666 is accepted the cycle after `value_ready` rises.
5. **Leading zeros:** `lz_suppress`=1 with 16'h0070.
   - Digits 3 and 2 show `seg`=7'h7F while their `an` bits still assert.
   - Digit 1 shows "7"; digit 0 shows "0".
   - With 16'h0000, only digit 0 is lit.
6. **Tick during blank:** force `tick` high during a BLANK cycle → ignored; `idx` advances exactly once per SHOW-state tick.
